// File: rtl/jeff_74x377_load_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : jeff_74x377_load_arbiter
// Description : Round-robin arbiter and load sequencer for one shared 74x377
//               octal register (8-bit D flip-flop, active-low clock enable).
//               One requester is picked in IDLE. Its byte is driven onto
//               d with en_bar low for exactly one capture edge (LOAD). The
//               winner then receives a one-cycle ack (ACK).
// Ports       : clk        - system clock, rising edge
//               rst        - synchronous active-high reset
//               req        - per-requester load request (level)
//               data_in    - requester i value on bits [8i+7:8i]
//               gnt        - one-hot grant, high during LOAD and ACK
//               ack        - one-hot one-cycle pulse, value captured
//               en_bar     - to 74x377 en_bar (active low)
//               d          - to 74x377 d7..d0
//               busy       - high in LOAD and ACK
//               owner      - index of the last granted requester
//               load_count - completed loads, saturating at 16'hFFFF
// Revision    : 1.0 - initial release
// ============================================================================
module jeff_74x377_load_arbiter #(
  parameter int NREQ = 4,
  parameter int PTRW = 2    // must equal ceil(log2(NREQ))
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*8-1:0]    data_in,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      ack,
  output logic                 en_bar,
  output logic [7:0]           d,
  output logic                 busy,
  output logic [PTRW-1:0]      owner,
  output logic [15:0]          load_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam logic [15:0]     c_COUNT_MAX = 16'hFFFF;
  localparam logic [PTRW-1:0] c_LAST_IDX  = PTRW'(NREQ - 1);

  state_t            r_state;
  state_t            w_state_next;

  logic [PTRW-1:0]   r_ptr;
  logic [PTRW-1:0]   w_ptr_next;
  logic [NREQ-1:0]   r_gnt;
  logic [NREQ-1:0]   w_gnt_next;
  logic [NREQ-1:0]   r_ack;
  logic [NREQ-1:0]   w_ack_next;
  logic              r_en_bar;
  logic              w_en_bar_next;
  logic [7:0]        r_d;
  logic [7:0]        w_d_next;
  logic              r_busy;
  logic              w_busy_next;
  logic [PTRW-1:0]   r_owner;
  logic [PTRW-1:0]   w_owner_next;
  logic [15:0]       r_load_count;
  logic [15:0]       w_load_count_next;

  // Round-robin search results
  logic              w_found;
  logic [PTRW-1:0]   w_win;
  int                w_idx;

  // Per-requester byte view of the flat data bus
  logic [7:0]        w_data [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_data_split
    assign w_data[gi] = data_in[8*gi +: 8];
  end

  // Winner: first requester found scanning r_ptr, r_ptr+1, ... modulo NREQ.
  // The last winner sits just behind r_ptr, so it is examined last.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = (int'(r_ptr) + k) % NREQ;
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = PTRW'(w_idx);
      end
    end
  end

  // State register and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_ptr        <= '0;
      r_gnt        <= '0;
      r_ack        <= '0;
      r_en_bar     <= 1'b1;
      r_d          <= 8'h00;
      r_busy       <= 1'b0;
      r_owner      <= '0;
      r_load_count <= 16'h0000;
    end else begin
      r_state      <= w_state_next;
      r_ptr        <= w_ptr_next;
      r_gnt        <= w_gnt_next;
      r_ack        <= w_ack_next;
      r_en_bar     <= w_en_bar_next;
      r_d          <= w_d_next;
      r_busy       <= w_busy_next;
      r_owner      <= w_owner_next;
      r_load_count <= w_load_count_next;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_next      = r_state;
    w_ptr_next        = r_ptr;
    w_gnt_next        = r_gnt;
    w_ack_next        = '0;      // ack is only ever a one-cycle pulse
    w_en_bar_next     = 1'b1;    // enable only ever low for one cycle
    w_d_next          = r_d;
    w_busy_next       = r_busy;
    w_owner_next      = r_owner;
    w_load_count_next = r_load_count;

    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          // data_in is sampled only here; later changes cannot disturb the load
          w_state_next      = ST_LOAD;
          w_gnt_next        = '0;
          w_gnt_next[w_win] = 1'b1;
          w_d_next          = w_data[w_win];
          w_en_bar_next     = 1'b0;
          w_owner_next      = w_win;
          w_busy_next       = 1'b1;
        end
      end

      ST_LOAD: begin
        // The 74x377 captures d at this closing edge
        w_state_next        = ST_ACK;
        w_ack_next[r_owner] = 1'b1;
        w_ptr_next          = (r_owner == c_LAST_IDX) ? '0 : r_owner + 1'b1;
        if (r_load_count != c_COUNT_MAX) begin
          w_load_count_next = r_load_count + 16'h0001;
        end
      end

      ST_ACK: begin
        w_state_next = ST_IDLE;
        w_gnt_next   = '0;
        w_busy_next  = 1'b0;
      end

      default: begin
        w_state_next = ST_IDLE;
        w_gnt_next   = '0;
        w_busy_next  = 1'b0;
      end
    endcase
  end

  assign gnt        = r_gnt;
  assign ack        = r_ack;
  assign en_bar     = r_en_bar;
  assign d          = r_d;
  assign busy       = r_busy;
  assign owner      = r_owner;
  assign load_count = r_load_count;

endmodule
`default_nettype wire

// File: doc/jeff_74x377_load_arbiter.md
Name: jeff_74x377_load_arbiter

Overview:
- Round-robin arbiter and load sequencer for one shared 74x377 octal register (8-bit D flip-flop with active-low clock enable).
- Up to NREQ requesters each present an 8-bit value with a req/ack handshake.
- The block picks one requester, drives the register's en_bar and d7..d0 for exactly one capture edge, then acknowledges the winner.
- It sits between requesting datapath blocks and the register instance, on the same clock as the register.

Parameters:
- NREQ, 4, number of requesters (2..8).
- PTRW, 2, width of the round-robin pointer and owner index; must equal ceil(log2(NREQ)).

Ports:
- clk  input  1  system clock; all state and the 74x377 update on the rising edge.
- rst  input  1  synchronous active-high reset.
- req  input  NREQ  per-requester load request, level.
- data_in  input  NREQ*8  requester i value on bits [8i+7:8i].
- gnt  output  NREQ  one-hot grant, high during LOAD and ACK.
- ack  output  NREQ  one-hot, one-cycle pulse: the value has been captured.
- en_bar  output  1  to 74x377 en_bar, active low.
- d  output  8  to 74x377 d7..d0 (d[7] drives d7).
- busy  output  1  high in LOAD and ACK.
- owner  output  PTRW  index of the last granted requester.
- load_count  output  16  number of completed loads, saturating.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values: state=IDLE, en_bar=1, d=8'h00, gnt=0, ack=0, busy=0, owner=0, pointer=0, load_count=0.
- All outputs are registered. There is no combinational path from req or data_in to any output.
- States: IDLE, LOAD, ACK.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise select the winner: the first i with req[i]=1, searching pointer, pointer+1, ... with wrap modulo NREQ.
  - At the next edge: state<=LOAD, gnt<=onehot(i), d<=data_in[i], en_bar<=0, owner<=i, busy<=1.
- LOAD (exactly one cycle):
  - en_bar is low for the whole cycle, so the 74x377 captures d at the closing edge.
  - At that edge: state<=ACK, en_bar<=1, ack<=onehot(owner), pointer<=(owner+1) mod NREQ, load_count<=load_count+1 (holds at 16'hFFFF).
  - d holds its value.
- ACK (exactly one cycle):
  - ack is high for one cycle; gnt stays asserted.
  - At the closing edge: state<=IDLE, ack<=0, gnt<=0, busy<=0.
- Latency: req sampled high in IDLE at edge E0 gives en_bar low E0..E1, register Q valid after E1, ack high E1..E2.
- Throughput: at most one load per 3 cycles.
- Handshake:
  - data_in is sampled only at the grant edge; later changes have no effect on the load in progress.
  - The requester must drop req in the cycle ack is high. A req still high at the next IDLE cycle is a new request.
  - A req deasserted during LOAD or ACK does not abort the load.
- Fairness:
  - The last winner has lowest priority in the next arbitration.
  - With all NREQ requesters continuously requesting, grants cycle 0,1,...,NREQ-1,0,...
- Simultaneous events:
  - New requests arriving during LOAD or ACK are ignored until IDLE.
  - A requester that raises req in the same cycle as another's ack competes normally at the next IDLE.
- Reset mid-operation:
  - rst sampled high during LOAD: en_bar was low that cycle, so the 74x377 still captures d at that edge. No ack is issued, load_count does not increment, and all outputs take reset values.
  - rst during ACK: the ack pulse ends at that edge.
- Invariants:
  - en_bar is never low for two consecutive cycles.
  - gnt and ack are always one-hot or zero.
  - ack implies the matching gnt bit.

Test Plan:
- Reset, then single requester: req=4'b0001, data_in[7:0]=8'hA5 → en_bar low one cycle, Q7..Q0=10100101 one edge later, ack=4'b0001 for one cycle, load_count=1, owner=0.
- All four requesting continuously, data_in = 11,22,33,44 hex for requesters 0..3:
  - grants in order 0,1,2,3,0; Q sequence 11,22,33,44,11; one load every 3 cycles; ack pulses one-hot in the same order.
- Pointer wrap: after a grant to requester 3, raise req=4'b1001 → requester 0 wins, then requester 3.
- data_in[15:8] changed from 8'h3C to 8'hFF one cycle after the grant to requester 1 → register captures 8'h3C; en_bar never low for 2 consecutive cycles.
- rst asserted in the LOAD cycle with data 8'h5A:
  - Q=8'h5A after that edge; no ack; gnt=0, busy=0, load_count unchanged.
  - Next request is granted starting from pointer 0.
- Force load_count to 16'hFFFF, then complete one more load → load_count stays 16'hFFFF and the ack is still issued.
